// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: single-edge multiply, restoring radix-2 divide.
// Optional build macro MULDIV_EARLY_OUT_EN: divisions with |dividend| < |divisor| skip the iterations.
module mul_div_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic [RD_W-1:0] RD_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [RD_W-1:0] RD_OUT
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op;
    logic [RD_W-1:0]  rd_tag;
    logic [XLEN-1:0]  mul_a, mul_b;
    logic [XLEN-1:0]  quo, rem, divisor;
    logic             quo_neg, rem_neg;
    logic [CNT_W-1:0] cnt;

    // Accept-time decode of the incoming request
    logic            accept;
    logic            is_div, signed_div;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, early_out;

    always_comb begin
        accept     = START && (state == S_IDLE || state == S_DONE);
        is_div     = FUNCT3[2];
        signed_div = FUNCT3[2] && !FUNCT3[0];
        a_neg      = signed_div && OPERAND_A[XLEN-1];
        b_neg      = signed_div && OPERAND_B[XLEN-1];
        a_mag      = a_neg ? -OPERAND_A : OPERAND_A;
        b_mag      = b_neg ? -OPERAND_B : OPERAND_B;
        div_zero   = (OPERAND_B == '0);
        div_ovf    = signed_div && (OPERAND_A == MIN_NEG) && (OPERAND_B == ALL_ONE);
`ifdef MULDIV_EARLY_OUT_EN
        early_out  = !div_zero && (a_mag < b_mag);
`else
        early_out  = 1'b0;
`endif
    end

    // Product: both operands extended to 2*XLEN; low 2*XLEN bits of the
    // unsigned product equal the two's-complement product.
    logic            a_sx, b_sx;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;

    always_comb begin
        a_sx  = (op != 2'b11) && mul_a[XLEN-1];
        b_sx  = (op == 2'b01) && mul_b[XLEN-1];
        a_ext = {{XLEN{a_sx}}, mul_a};
        b_ext = {{XLEN{b_sx}}, mul_b};
        prod  = a_ext * b_ext;
    end

    // One restoring step: shift in next dividend bit, subtract if it fits
    logic [XLEN:0]   shifted, trial;
    logic            fits;
    logic [XLEN-1:0] rem_step, quo_step;

    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        trial    = shifted - {1'b0, divisor};
        fits     = !trial[XLEN];
        rem_step = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_step = {quo[XLEN-2:0], fits};
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                DONE = (state == S_DONE);
                if (accept) begin
                    if (!is_div)                                state_nxt = S_MUL;
                    else if (div_zero || div_ovf || early_out)  state_nxt = S_FIX;
                    else                                        state_nxt = S_DIV;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                BUSY      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DIV: begin
                BUSY = 1'b1;
                if (cnt == LAST_CNT) state_nxt = S_FIX;
            end
            S_FIX: begin
                BUSY      = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op      <= '0;
            rd_tag  <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
            RESULT  <= '0;
            RD_OUT  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op      <= FUNCT3[1:0];
                        rd_tag  <= RD_IN;
                        mul_a   <= OPERAND_A;
                        mul_b   <= OPERAND_B;
                        divisor <= b_mag;
                        cnt     <= '0;
                        // Special cases preload final values with no sign fix
                        if (div_zero) begin
                            quo     <= ALL_ONE;
                            rem     <= OPERAND_A;
                            quo_neg <= 1'b0;
                            rem_neg <= 1'b0;
                        end else if (div_ovf) begin
                            quo     <= MIN_NEG;
                            rem     <= '0;
                            quo_neg <= 1'b0;
                            rem_neg <= 1'b0;
                        end else if (early_out) begin
                            quo     <= '0;
                            rem     <= a_mag;
                            quo_neg <= a_neg ^ b_neg;
                            rem_neg <= a_neg;
                        end else begin
                            quo     <= a_mag;
                            rem     <= '0;
                            quo_neg <= a_neg ^ b_neg;
                            rem_neg <= a_neg;
                        end
                    end
                end
                S_MUL: begin
                    RESULT <= (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    RD_OUT <= rd_tag;
                end
                S_DIV: begin
                    quo <= quo_step;
                    rem <= rem_step;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (op[1]) RESULT <= rem_neg ? -rem : rem;
                    else       RESULT <= quo_neg ? -quo : quo;
                    RD_OUT <= rd_tag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] OPERAND_A, OPERAND_B;
    logic [4:0]  RD_IN;
    logic        BUSY, DONE;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    mul_div_unit dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .RD_IN(RD_IN),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RD_OUT(RD_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        ia = a;          ib = b;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                  else return ia / ib;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                  else return ia % ib;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges from accept to the edge after which DONE is high
    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic [31:0] ma, mb;
        sgn = f[2] && !f[0];
        if (!f[2]) return 1;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = (sgn && a[31]) ? 32'(0 - a) : a;
        mb = (sgn && b[31]) ? 32'(0 - b) : b;
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Issue one op (inputs presented now, accepted at next edge) and check it
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        int n;
        FUNCT3 = f; OPERAND_A = a; OPERAND_B = b; RD_IN = rd; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        OPERAND_A = $urandom; OPERAND_B = $urandom; FUNCT3 = 3'($urandom); RD_IN = 5'($urandom);
        n = 0;
        while (!DONE && n < 40) begin
            chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_lat"}, n, model_lat(f, a, b));
        chk({tag, "_done"}, {31'b0, DONE}, 32'd1);
        chk({tag, "_res"}, RESULT, model(f, a, b));
        chk({tag, "_rd"}, {27'b0, RD_OUT}, {27'b0, rd});
    endtask

    initial begin
        int dones, done_at;
        logic [31:0] res_at;
        logic [2:0] f;
        logic [31:0] a, b;

        RESET = 1'b1; START = 1'b0; FUNCT3 = '0; OPERAND_A = '0; OPERAND_B = '0; RD_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_done", {31'b0, DONE}, 32'd0);
        chk("rst_res", RESULT, 32'd0);
        chk("rst_rd", {27'b0, RD_OUT}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Directed cases; consecutive calls also exercise back-to-back accept from DONE
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul");
        chk("mul_res_const", RESULT, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, "mulhsu");
        @(posedge CLK); #1;
        chk("idle_done", {31'b0, DONE}, 32'd0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, "div");
        chk("div_res_const", RESULT, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd11, "divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd12, "remu");
        run_op(3'd5, 32'd5, 32'd0, 5'd13, "divu0");
        run_op(3'd6, 32'd5, 32'd0, 5'd14, "rem0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "divovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, "removf");
        run_op(3'd5, 32'd3, 32'd10, 5'd17, "early");
        @(posedge CLK); #1;

        // START during an in-flight DIV must be ignored
        FUNCT3 = 3'd5; OPERAND_A = 32'd1000; OPERAND_B = 32'd3; RD_IN = 5'd20; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        dones = 0; done_at = 0; res_at = '0;
        for (int n = 1; n <= 50; n++) begin
            if (n == 6) begin
                FUNCT3 = 3'd0; OPERAND_A = 32'd2; OPERAND_B = 32'd2; RD_IN = 5'd21; START = 1'b1;
            end
            @(posedge CLK); #1;
            START = 1'b0;
            if (DONE) begin
                dones++;
                if (dones == 1) begin done_at = n; res_at = RESULT; end
            end
        end
        chk("hs_dones", dones, 32'd1);
        chk("hs_lat", done_at, 32'd33);
        chk("hs_res", res_at, 32'd333);
        chk("hs_rd", {27'b0, RD_OUT}, 32'd20);

        // Reset at E10 of a DIV aborts without DONE
        FUNCT3 = 3'd4; OPERAND_A = 32'd12345; OPERAND_B = 32'd17; RD_IN = 5'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("mrst_busy", {31'b0, BUSY}, 32'd0);
        chk("mrst_done", {31'b0, DONE}, 32'd0);
        chk("mrst_res", RESULT, 32'd0);
        chk("mrst_rd", {27'b0, RD_OUT}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        chk("mrst_nodone", dones, 32'd0);

        // Random ops with biased operand classes
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(51, 500); end
                3: b = $urandom_range(1, 20);
                default: ;
            endcase
            run_op(f, a, b, 5'($urandom), "rand");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge CLK); #1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
